// File: rtl/req_arbiter8_ctrl.sv
// Eight-way request arbiter for one shared datapath: fixed highest-index or
// round-robin selection, grant hold with owner release and hold timeout.
module req_arbiter8_ctrl #(
  parameter int MAX_HOLD = 16,
  parameter int GAP_CYC  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  input  logic       mode_rr,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout,
  output logic [1:0] state_dbg
);

  // Handshake: requester i holds req[i] high until served; the arbiter answers
  // with gnt[i]/gnt_valid; the owner ends the grant with a one-cycle done pulse
  // or by dropping req[i]. done outside a grant is ignored.

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state;
  logic [2:0]      last_idx;
  logic [HW-1:0]   hold_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [2:0]      win_fix;
  logic [2:0]      win_rr;
  logic [2:0]      win;
  logic [2:0]      rr_idx;
  logic            hold_max;
  logic            owner_req;

  assign state_dbg = state;
  assign hold_max  = (hold_cnt == HW'(MAX_HOLD - 1));
  assign owner_req = req[gnt_idx];

  // Round-robin scans last_idx-1 downward; walking offsets 8..1 and keeping the
  // last hit leaves the smallest offset, so last_idx itself is searched last.
  always_comb begin
    win_fix = 3'd0;
    win_rr  = 3'd0;
    rr_idx  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) win_fix = 3'(i);
    end
    for (int k = 8; k >= 1; k--) begin
      rr_idx = last_idx - 3'(k);
      if (req[rr_idx]) win_rr = rr_idx;
    end
    win = mode_rr ? win_rr : win_fix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      gnt       <= 8'd0;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      last_idx  <= 3'd0;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ARB: begin
          if (|req) begin
            gnt       <= 8'd1 << win;
            gnt_idx   <= win;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (done || !owner_req || hold_max) begin
            gnt       <= 8'd0;
            gnt_valid <= 1'b0;
            last_idx  <= gnt_idx;
            gap_cnt   <= '0;
            state     <= GAP;
            // Only a pure hold expiry counts as a revocation.
            timeout   <= !done && owner_req;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYC - 1)) state <= ARB;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_req_arbiter8_ctrl.sv
// Bench for req_arbiter8_ctrl: directed grant sessions, each pushing its
// expected owner/length/timeout/gap; a negedge monitor pops on every release.
module tb_req_arbiter8_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic       mode_rr;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;
  logic [1:0] state_dbg;

  int n_vec;
  int n_err;
  bit mon_en;

  // record: {idx[2:0], len[7:0], timeout, gap[7:0]}; gap 0 means unchecked
  logic [19:0] exp_q[$];

  req_arbiter8_ctrl #(.MAX_HOLD(16), .GAP_CYC(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .mode_rr   (mode_rr),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] idx, input int len, input bit to, input int gap);
    exp_q.push_back({idx, 8'(len), to, 8'(gap)});
  endtask

  task automatic do_reset();
    req = 8'h00;
    done = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // act 0: pulse done in the hold_cnt==d cycle, then req=r_after.
  // act 1: set req=r_after in the hold_cnt==d cycle, wait for release.
  task automatic grant(input logic [7:0] r_on, input int d, input int act,
                       input logic [7:0] r_after, input logic [2:0] e_idx,
                       input int e_len, input bit e_to, input int e_gap);
    int k;
    push_exp(e_idx, e_len, e_to, e_gap);
    req = r_on;
    k = 0;
    while (gnt_valid !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk("grant_seen", {31'd0, gnt_valid}, 32'd1);
    if (gnt_valid !== 1'b1) return;
    repeat (d) tick();
    if (act == 0) begin
      done = 1'b1;
      tick();
      done = 1'b0;
      req = r_after;
    end else begin
      req = r_after;
      tick();
    end
    k = 0;
    while (gnt_valid === 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk("release_seen", {31'd0, gnt_valid}, 32'd0);
  endtask

  // monitor / scoreboard
  bit prev_v;
  int run_len;
  int gap_len;
  int rise_gap;
  logic [2:0] rise_idx;
  logic [19:0] e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (gnt_valid === 1'b1) begin
        chk("gnt_onehot", gnt, 32'(8'd1 << gnt_idx));
        chk("timeout_while_held", timeout, 0);
        if (!prev_v) begin
          rise_idx = gnt_idx;
          rise_gap = gap_len;
          run_len = 1;
        end else begin
          run_len++;
        end
      end else begin
        chk("gnt_zero_idle", gnt, 0);
        if (prev_v) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_release: got release of idx %0d expected none", rise_idx);
          end else begin
            e = exp_q.pop_front();
            chk("owner_idx", rise_idx, e[19:17]);
            chk("hold_len", run_len, e[16:9]);
            chk("timeout_at_release", timeout, e[8]);
            if (e[7:0] != 8'd0) chk("gap_len", rise_gap, e[7:0]);
          end
          gap_len = 1;
        end else begin
          chk("timeout_idle", timeout, 0);
          gap_len++;
        end
      end
      prev_v = (gnt_valid === 1'b1);
    end
  end

  // driver
  initial begin
    n_vec = 0;
    n_err = 0;
    mon_en = 1'b0;
    prev_v = 1'b0;
    gap_len = 0;
    rst = 1'b1;
    req = 8'hFF;
    done = 1'b0;
    mode_rr = 1'b0;

    // reset with all requests pending
    tick();
    chk("rst1_gnt", gnt, 0);
    chk("rst1_valid", gnt_valid, 0);
    chk("rst1_timeout", timeout, 0);
    mon_en = 1'b1;
    tick();
    chk("rst2_gnt", gnt, 0);
    chk("rst2_valid", gnt_valid, 0);
    chk("rst2_idx", gnt_idx, 0);
    rst = 1'b0;
    push_exp(3'd7, 1, 1'b0, 0);
    tick();
    chk("first_grant", gnt, 8'h80);
    done = 1'b1;
    tick();
    done = 1'b0;
    req = 8'h00;
    repeat (3) tick();

    // fixed priority
    grant(8'h26, 2, 0, 8'h26, 3'd5, 3, 1'b0, 0);
    grant(8'h26, 2, 0, 8'h06, 3'd5, 3, 1'b0, 2);
    grant(8'h06, 2, 0, 8'h02, 3'd2, 3, 1'b0, 2);
    grant(8'h02, 2, 0, 8'h00, 3'd1, 3, 1'b0, 2);
    repeat (3) tick();

    // round-robin from last_idx=0
    do_reset();
    mode_rr = 1'b1;
    for (int i = 0; i < 9; i++) begin
      grant(8'hFF, 1, 0, (i == 8) ? 8'h00 : 8'hFF, 3'((7 - i) & 7), 2, 1'b0, (i == 0) ? 0 : 2);
    end
    repeat (3) tick();

    // hold timeout, then re-grant after the gap
    mode_rr = 1'b0;
    grant(8'h08, 0, 1, 8'h08, 3'd3, 16, 1'b1, 0);
    grant(8'h08, 0, 0, 8'h00, 3'd3, 1, 1'b0, 2);

    // done or withdrawal coinciding with the last hold cycle; withdrawal; no preemption
    grant(8'h08, 15, 0, 8'h00, 3'd3, 16, 1'b0, 0);
    grant(8'h10, 2, 1, 8'h00, 3'd4, 3, 1'b0, 0);
    grant(8'h10, 15, 1, 8'h00, 3'd4, 16, 1'b0, 0);
    grant(8'h04, 3, 1, 8'h84, 3'd2, 16, 1'b1, 0);
    grant(8'h84, 0, 0, 8'h00, 3'd7, 1, 1'b0, 2);
    repeat (3) tick();

    // reset in the middle of a round-robin grant
    mode_rr = 1'b1;
    push_exp(3'd4, 2, 1'b0, 0);
    req = 8'h10;
    tick();
    tick();
    chk("mid_pre_idx", gnt_idx, 3'd4);
    rst = 1'b1;
    req = 8'hFF;
    tick();
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_valid", gnt_valid, 0);
    chk("mid_rst_idx", gnt_idx, 0);
    chk("mid_rst_timeout", timeout, 0);
    rst = 1'b0;
    push_exp(3'd7, 1, 1'b0, 0);
    tick();
    chk("post_rst_grant", gnt, 8'h80);
    done = 1'b1;
    tick();
    done = 1'b0;
    req = 8'h00;

    repeat (4) tick();
    chk("queue_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
